// File: rtl/bw_mult_pkg.sv
// Sizing helpers shared by the pipelined Baugh-Wooley multiplier and its
// reduction layer.
package bw_mult_pkg;

    localparam int MAX_PROD_W = 128;

    function automatic int num_red_stages(input int m, input int lps);
        return (m - 1 + lps - 1) / lps;
    endfunction

    function automatic int latency(input int m, input int lps);
        return num_red_stages(m, lps) + 2;
    endfunction

    // The two constant ones that turn the complemented sign terms into a
    // proper two's-complement product: 2^m + 2^(2m-1).
    function automatic logic [MAX_PROD_W-1:0] bw_correction(input int m);
        logic [MAX_PROD_W-1:0] c;
        c = '0;
        c[m] = 1'b1;
        c[2*m-1] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/bw_reduction_layer.sv
// One carry-save layer: folds partial-product row ROW into the running
// sum/carry pair and retires the lowest sum bit as a finished product bit.
module bw_reduction_layer
    import bw_mult_pkg::*;
#(
    parameter int M   = 8,
    parameter int ROW = 1
) (
    input  logic [M-1:0] pp,
    input  logic [M-1:0] sum_in,
    input  logic [M-1:0] carry_in,
    input  logic         is_signed,
    output logic [M-1:0] sum_out,
    output logic [M-1:0] carry_out,
    output logic         prod_bit
);

    // Last row complements everything except its sign bit; other rows only
    // complement their top bit.
    localparam logic [M-1:0] FLIP = (ROW == M - 1) ? {1'b0, {(M-1){1'b1}}}
                                                   : {1'b1, {(M-1){1'b0}}};

    logic [M-1:0] row;
    logic [M-1:0] sum_hi;

    // sum_in[j] sits one column below carry_in[j]; shifting aligns them.
    assign row       = pp ^ (is_signed ? FLIP : '0);
    assign sum_hi    = {1'b0, sum_in[M-1:1]};
    assign sum_out   = sum_hi ^ carry_in ^ row;
    assign carry_out = (sum_hi & carry_in) | (sum_hi & row) | (carry_in & row);
    assign prod_bit  = sum_in[0];

endmodule

// File: rtl/bw_pipelined_multiplier.sv
// Pipelined M x M Baugh-Wooley multiplier with runtime signed/unsigned mode
// and valid/ready flow control; one product per cycle when not stalled.
module bw_pipelined_multiplier
    import bw_mult_pkg::*;
#(
    parameter int M                = 8,
    parameter int LAYERS_PER_STAGE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*M-1:0] out_product
);

    localparam int LPS = LAYERS_PER_STAGE;
    localparam int NR  = num_red_stages(M, LPS);
    localparam logic [2*M-1:0] CORR = (2*M)'(bw_correction(M));

    logic           stall;
    logic           vld_reg   [0:NR];
    logic           sgn_reg   [0:NR];
    logic [M-1:0]   pp_reg    [0:NR][0:M-1];
    logic [M-1:0]   sum_reg   [1:NR];
    logic [M-1:0]   carry_reg [1:NR];
    logic [M-2:0]   ret_reg   [1:NR];
    logic [M-1:0]   lay_sum   [1:M-1];
    logic [M-1:0]   lay_carry [1:M-1];
    logic [M-2:0]   lay_ret   [1:M-1];
    logic [M-1:0]   row0;
    logic [2*M-1:0] merged;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign row0     = pp_reg[0][0] ^ {sgn_reg[0], {(M-1){1'b0}}};

    genvar gi;

    // Stage 0: raw partial products and the operand mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_reg[0] <= 1'b0;
        end else if (!stall) begin
            vld_reg[0] <= in_valid & in_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            sgn_reg[0] <= is_signed;
        end
    end

    for (gi = 0; gi < M; gi++) begin : g_pp
        always_ff @(posedge clk) begin
            if (!stall) begin
                pp_reg[0][gi] <= a & {M{b[gi]}};
            end
        end
    end

    // Layer gi consumes row gi+1; the first layer of each stage reads the
    // previous stage's registers, the others chain combinationally.
    for (gi = 0; gi < M - 1; gi++) begin : g_layer
        localparam int STG = gi / LPS + 1;
        logic [M-1:0] s_in;
        logic [M-1:0] c_in;
        logic [M-2:0] r_in;
        logic         bit_out;

        if (gi == 0) begin : g_src_pp
            assign s_in = row0;
            assign c_in = '0;
            assign r_in = '0;
        end else if ((gi % LPS) == 0) begin : g_src_reg
            assign s_in = sum_reg[STG-1];
            assign c_in = carry_reg[STG-1];
            assign r_in = ret_reg[STG-1];
        end else begin : g_src_chain
            assign s_in = lay_sum[gi];
            assign c_in = lay_carry[gi];
            assign r_in = lay_ret[gi];
        end

        bw_reduction_layer #(.M(M), .ROW(gi + 1)) u_layer (
            .pp        (pp_reg[STG-1][gi+1]),
            .sum_in    (s_in),
            .carry_in  (c_in),
            .is_signed (sgn_reg[STG-1]),
            .sum_out   (lay_sum[gi+1]),
            .carry_out (lay_carry[gi+1]),
            .prod_bit  (bit_out)
        );

        assign lay_ret[gi+1] = r_in | ((M-1)'(bit_out) << gi);
    end

    // Reduction stages; the last one may hold fewer than LPS layers.
    for (gi = 1; gi <= NR; gi++) begin : g_stage
        localparam int BND = (gi * LPS < M - 1) ? gi * LPS : M - 1;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_reg[gi] <= 1'b0;
            end else if (!stall) begin
                vld_reg[gi] <= vld_reg[gi-1];
            end
        end

        always_ff @(posedge clk) begin
            if (!stall) begin
                sgn_reg[gi]   <= sgn_reg[gi-1];
                pp_reg[gi]    <= pp_reg[gi-1];
                sum_reg[gi]   <= lay_sum[BND];
                carry_reg[gi] <= lay_carry[BND];
                ret_reg[gi]   <= lay_ret[BND];
            end
        end
    end

    // Carry-propagate merge; the retired low bits sit under the sum/carry pair.
    assign merged = ((2*M)'(sum_reg[NR]) << (M - 1))
                  + ((2*M)'(carry_reg[NR]) << M)
                  + (2*M)'(ret_reg[NR])
                  + (sgn_reg[NR] ? CORR : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_product <= '0;
        end else if (!stall) begin
            out_valid <= vld_reg[NR];
            if (vld_reg[NR]) begin
                out_product <= merged;
            end
        end
    end

endmodule

// File: tb/tb_bw_pipelined_multiplier.sv
// Self-checking bench for bw_pipelined_multiplier (M=8, LAYERS_PER_STAGE=2)
// against an integer-arithmetic reference model.
module tb_bw_pipelined_multiplier;

    localparam int M   = 8;
    localparam int LPS = 2;
    localparam int LAT = (M - 1 + LPS - 1) / LPS + 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [M-1:0]   a;
    logic [M-1:0]   b;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*M-1:0] out_product;

    bw_pipelined_multiplier #(.M(M), .LAYERS_PER_STAGE(LPS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*M-1:0] prod;
        int             acc;
    } exp_t;

    exp_t           exp_q[$];
    int             errors = 0;
    int             checks = 0;
    int             cyc = 0;
    logic           got_out, took_in, q_empty, rdy_seen;
    logic [2*M-1:0] obs_prod, exp_prod;
    int             exp_lat;

    function automatic logic [2*M-1:0] ref_model(input logic [M-1:0] x,
                                                 input logic [M-1:0] y,
                                                 input logic s);
        longint px, py;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'(x);
            py = longint'(y);
        end
        return (2*M)'(px * py);
    endfunction

    function automatic logic [M-1:0] pick();
        int unsigned r;
        r = $urandom % 8;
        case (r)
            0: return '0;
            1: return '1;
            2: return {1'b1, {(M-1){1'b0}}};
            3: return {1'b0, {(M-1){1'b1}}};
            4: return (M)'(1);
            default: return (M)'($urandom);
        endcase
    endfunction

    // One clock: sample handshakes at the falling edge, keep the scoreboard.
    task automatic step();
        exp_t e;
        @(negedge clk);
        rdy_seen = in_ready;
        obs_prod = out_product;
        got_out  = out_valid && out_ready;
        took_in  = in_valid && in_ready;
        q_empty  = 1'b0;
        if (got_out) begin
            if (exp_q.size() == 0) begin
                q_empty = 1'b1;
            end else begin
                e        = exp_q.pop_front();
                exp_prod = e.prod;
                exp_lat  = cyc - e.acc;
            end
        end
        if (took_in) begin
            e.prod = ref_model(a, b, is_signed);
            e.acc  = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 8'h12; b = 8'h34; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_product !== 16'h0000) begin errors++; $display("FAIL reset_out_product got=%h want=0000", out_product); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b want=0", out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_unsigned_max();
        int seen = 0;
        out_ready = 1'b1;
        a = 8'hFF; b = 8'hFF; is_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (took_in !== 1'b1) begin errors++; $display("FAIL umax_accept got=%b want=1", took_in); end
        for (int n = 0; n < 20 && seen == 0; n++) begin
            step();
            if (got_out) begin
                seen = 1;
                checks++; if (q_empty || obs_prod !== 16'hFE01) begin errors++; $display("FAIL umax_product got=%h want=fe01", obs_prod); end
                checks++; if (exp_lat !== LAT) begin errors++; $display("FAIL umax_latency got=%0d want=%0d", exp_lat, LAT); end
                $display("umax: 255*255 -> %h latency %0d", obs_prod, exp_lat);
            end
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL umax_timeout got=none want=result"); end
    endtask

    task automatic test_signed_corners();
        logic [M-1:0]   va [4];
        logic [M-1:0]   vb [4];
        logic [2*M-1:0] want [4];
        int k = 0;
        va = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        vb = '{8'h80, 8'h01, 8'h80, 8'hFB};
        want = '{16'h4000, 16'hFFFF, 16'hC080, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i]; is_signed = 1'b1; in_valid = 1'b1;
            step();
            checks++; if (took_in !== 1'b1) begin errors++; $display("FAIL corner_accept[%0d] got=%b want=1", i, took_in); end
        end
        in_valid = 1'b0;
        for (int n = 0; n < 30 && k < 4; n++) begin
            step();
            if (got_out) begin
                checks++; if (q_empty || obs_prod !== want[k]) begin errors++; $display("FAIL corner_product[%0d] got=%h want=%h", k, obs_prod, want[k]); end
                checks++; if (exp_lat !== LAT) begin errors++; $display("FAIL corner_latency[%0d] got=%0d want=%0d", k, exp_lat, LAT); end
                $display("corner %0d: %h * %h signed -> %h", k, va[k], vb[k], obs_prod);
                k++;
            end
        end
        checks++; if (k != 4) begin errors++; $display("FAIL corner_count got=%0d want=4", k); end
    endtask

    task automatic test_mixed_modes();
        logic [2*M-1:0] want [2];
        int k = 0;
        want = '{16'hFE01, 16'h0001};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = 8'hFF; b = 8'hFF; is_signed = (i == 1); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int n = 0; n < 30 && k < 2; n++) begin
            step();
            if (got_out) begin
                checks++; if (q_empty || obs_prod !== want[k]) begin errors++; $display("FAIL mixed_product[%0d] got=%h want=%h", k, obs_prod, want[k]); end
                checks++; if (exp_lat !== LAT) begin errors++; $display("FAIL mixed_latency[%0d] got=%0d want=%0d", k, exp_lat, LAT); end
                $display("mixed %0d: ff*ff mode=%0d -> %h", k, k, obs_prod);
                k++;
            end
        end
        checks++; if (k != 2) begin errors++; $display("FAIL mixed_count got=%0d want=2", k); end
    endtask

    task automatic test_backpressure();
        logic [M-1:0]   sa [10];
        logic [M-1:0]   sb [10];
        logic           ss [10];
        logic [2*M-1:0] held = '0;
        logic           want_rdy;
        int sent = 0, recv = 0;
        for (int i = 0; i < 10; i++) begin
            sa[i] = pick(); sb[i] = pick(); ss[i] = 1'($urandom);
        end
        for (int n = 0; n < 60 && recv < 10; n++) begin
            in_valid  = (sent < 10);
            a         = (sent < 10) ? sa[sent] : '0;
            b         = (sent < 10) ? sb[sent] : '0;
            is_signed = (sent < 10) ? ss[sent] : 1'b0;
            out_ready = !(n >= 8 && n < 13);
            want_rdy  = out_ready;
            step();
            if (took_in) sent++;
            checks++; if (rdy_seen !== want_rdy) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=%b", n, rdy_seen, want_rdy); end
            if (n == 8) held = obs_prod;
            if (n > 8 && n < 13) begin
                checks++; if (obs_prod !== held) begin errors++; $display("FAIL bp_stable[%0d] got=%h want=%h", n, obs_prod, held); end
            end
            if (got_out) begin
                checks++; if (q_empty || obs_prod !== exp_prod) begin errors++; $display("FAIL bp_product[%0d] got=%h want=%h", recv, obs_prod, exp_prod); end
                $display("bp %0d: cycle %0d -> %h", recv, n, obs_prod);
                recv++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            checks++; if (got_out) begin errors++; $display("FAIL bp_duplicate got=%h want=none", obs_prod); end
        end
        checks++; if (recv != 10 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count got=%0d want=10", recv); end
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = pick(); b = pick(); is_signed = 1'($urandom); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int n = 0; n < 20 && out_valid !== 1'b1; n++) step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_prefill got=%b want=1", out_valid); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
        checks++; if (out_product !== 16'h0000) begin errors++; $display("FAIL rst_mid_product got=%h want=0000", out_product); end
        exp_q.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step();
            checks++; if (got_out) begin errors++; $display("FAIL rst_stale got=%h want=none", obs_prod); end
        end
        $display("reset mid-stream: in-flight results discarded");
    endtask

    task automatic test_random_soak();
        localparam int N = 3000;
        int sent = 0, recv = 0;
        for (int n = 0; n < N * 8 && recv < N; n++) begin
            if (!(in_valid && !took_in)) begin
                in_valid  = (sent < N) && ($urandom % 5 != 0);
                a         = pick();
                b         = pick();
                is_signed = 1'($urandom);
            end
            out_ready = ($urandom % 4 != 0);
            step();
            if (took_in) sent++;
            if (got_out) begin
                checks++; if (q_empty || obs_prod !== exp_prod) begin errors++; $display("FAIL soak_product[%0d] got=%h want=%h", recv, obs_prod, exp_prod); end
                checks++; if (exp_lat < LAT) begin errors++; $display("FAIL soak_latency[%0d] got=%0d want>=%0d", recv, exp_lat, LAT); end
                recv++;
            end
        end
        in_valid = 1'b0;
        checks++; if (recv != N || exp_q.size() != 0) begin errors++; $display("FAIL soak_count got=%0d want=%0d", recv, N); end
        $display("soak: %0d products compared", recv);
    endtask

    initial begin
        took_in = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_mixed_modes();
        test_backpressure();
        test_reset_mid_stream();
        test_random_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
